// File: rtl/uart_pkg.sv
// Shared UART definitions: Tx state encoding, parity helper and the legal
// parameter ranges common to the Tx and Rx blocks.
package uart_pkg;

  localparam int DATA_W_MIN       = 5;
  localparam int DATA_W_MAX       = 9;
  localparam int CLKS_PER_BIT_MIN = 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_t;

  // Callers zero-extend narrower words; the extra zeros do not change the XOR.
  function automatic logic parity_bit(input logic [DATA_W_MAX-1:0] data,
                                      input logic                  odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and pulses
// bit_done on the last cycle of each bit. Shared by the Tx and Rx sides.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  input  logic enable,
  output logic bit_done
);

  if (CLKS_PER_BIT < CLKS_PER_BIT_MIN) begin : g_bad_clks_per_bit
    $error("uart_bit_timer: CLKS_PER_BIT must be at least %0d", CLKS_PER_BIT_MIN);
  end

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  assign bit_done = enable && (cnt_q == LAST);

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: accepts a word over valid/ready and sends start, DATA_W
// data bits LSB-first, optional parity and one or two stop bits.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic              parity_en,
  input  logic              parity_odd,
  input  logic              two_stop,
  output logic              tx_out,
  output logic              busy
);

  if (DATA_W < DATA_W_MIN || DATA_W > DATA_W_MAX) begin : g_bad_data_w
    $error("uart_tx_frame: DATA_W must be in %0d..%0d", DATA_W_MIN, DATA_W_MAX);
  end

  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_W - 1);

  uart_tx_state_t    state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic              parity_en_q, parity_q, two_stop_q;
  logic              tx_d;
  logic              accept, bit_done, last_data, last_stop;

  assign tx_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign accept    = tx_ready && tx_valid;
  assign last_data = (bit_cnt_q == LAST_DATA);
  assign last_stop = (bit_cnt_q == (two_stop_q ? CNT_W'(1) : CNT_W'(0)));

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk     (clk),
    .resetn  (resetn),
    .clear   (accept),
    .enable  (busy),
    .bit_done(bit_done)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // NOTE: every variable assigned here gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (tx_valid) state_d = START;
      START:   if (bit_done) state_d = DATA;
      DATA:    if (bit_done && last_data) state_d = parity_en_q ? PARITY : STOP;
      PARITY:  if (bit_done) state_d = STOP;
      STOP:    if (bit_done && last_stop) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // tx_out is registered from the level the next state will drive, which
  // gives the one-cycle acceptance-to-start-bit latency.
  always_comb begin
    shift_d = shift_q;
    if (accept) begin
      shift_d = tx_data;
    end else if (state_q == DATA && bit_done) begin
      shift_d = shift_q >> 1;
    end

    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = parity_q;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      parity_en_q <= 1'b0;
      parity_q    <= 1'b0;
      two_stop_q  <= 1'b0;
      tx_out      <= 1'b1;
    end else begin
      shift_q <= shift_d;
      tx_out  <= tx_d;
      if (state_d != state_q) begin
        bit_cnt_q <= '0;
      end else if (bit_done) begin
        bit_cnt_q <= bit_cnt_q + 1'b1;
      end
      if (accept) begin
        parity_en_q <= parity_en;
        two_stop_q  <= two_stop;
        parity_q    <= parity_bit(DATA_W_MAX'(tx_data), parity_odd);
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: an 8-bit/4-clock instance and a
// 5-bit/2-clock instance checked against hand-written bit sequences.
module tb_uart_tx_frame;

  logic clk = 1'b0;
  logic resetn;

  logic [7:0] data8;
  logic       valid8, pen8, podd8, ts8, rdy8, tx8, busy8;
  logic [4:0] data5;
  logic       valid5, pen5, podd5, ts5, rdy5, tx5, busy5;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  uart_tx_frame #(.DATA_W(8), .CLKS_PER_BIT(4)) u_dut8 (
    .clk(clk), .resetn(resetn), .tx_data(data8), .tx_valid(valid8),
    .tx_ready(rdy8), .parity_en(pen8), .parity_odd(podd8), .two_stop(ts8),
    .tx_out(tx8), .busy(busy8)
  );

  uart_tx_frame #(.DATA_W(5), .CLKS_PER_BIT(2)) u_dut5 (
    .clk(clk), .resetn(resetn), .tx_data(data5), .tx_valid(valid5),
    .tx_ready(rdy5), .parity_en(pen5), .parity_odd(podd5), .two_stop(ts5),
    .tx_out(tx5), .busy(busy5)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int dut, input logic [8:0] d, input logic v,
                       input logic pen, input logic podd, input logic ts);
    if (dut == 0) begin
      data8 = d[7:0]; valid8 = v; pen8 = pen; podd8 = podd; ts8 = ts;
    end else begin
      data5 = d[4:0]; valid5 = v; pen5 = pen; podd5 = podd; ts5 = ts;
    end
  endtask

  function automatic logic cur_tx(input int dut);
    return (dut == 0) ? tx8 : tx5;
  endfunction

  function automatic logic cur_ready(input int dut);
    return (dut == 0) ? rdy8 : rdy5;
  endfunction

  function automatic logic cur_busy(input int dut);
    return (dut == 0) ? busy8 : busy5;
  endfunction

  // Called one cycle into IDLE; accepts one word and checks every cycle of
  // the frame against exp (bits in line order), then the following idle cycle.
  task automatic send_frame(input int dut, input logic [8:0] d, input logic pen,
                            input logic podd, input logic ts, input string exp,
                            input string name);
    int   cpb;
    int   low;
    logic e;
    cpb = (dut == 0) ? 4 : 2;
    low = 0;
    total++;
    if (cur_ready(dut) !== 1'b1)
      $display("FAIL %s ready_before: tx_ready=%b expected 1", name, cur_ready(dut));
    else passed++;
    drive(dut, d, 1'b1, pen, podd, ts);
    tick();
    drive(dut, ~d, 1'b0, ~pen, ~podd, ~ts);
    for (int i = 0; i < exp.len(); i++) begin
      e = (exp[i] == "1");
      for (int c = 0; c < cpb; c++) begin
        total++;
        if (cur_tx(dut) !== e)
          $display("FAIL %s bit %0d cycle %0d: tx_out=%b expected %b", name, i, c, cur_tx(dut), e);
        else passed++;
        if (i == 0 && c == 0) begin
          total++;
          if (cur_busy(dut) !== 1'b1)
            $display("FAIL %s busy: busy=%b expected 1", name, cur_busy(dut));
          else passed++;
        end
        if (cur_ready(dut) === 1'b0) low++;
        tick();
      end
    end
    total++;
    if (cur_ready(dut) !== 1'b1 || cur_tx(dut) !== 1'b1)
      $display("FAIL %s idle_after: tx_ready=%b tx_out=%b expected 1 1", name, cur_ready(dut), cur_tx(dut));
    else passed++;
    total++;
    if (low != exp.len() * cpb)
      $display("FAIL %s ready_low: %0d cycles expected %0d", name, low, exp.len() * cpb);
    else passed++;
  endtask

  task automatic test_reset();
    int bad8;
    int bad5;
    resetn = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(0, 9'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      drive(1, 9'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      tick();
    end
    total++;
    if ({tx8, rdy8, busy8} !== 3'b110)
      $display("FAIL reset_dut8: tx_out,tx_ready,busy=%b expected 110", {tx8, rdy8, busy8});
    else passed++;
    total++;
    if ({tx5, rdy5, busy5} !== 3'b110)
      $display("FAIL reset_dut5: tx_out,tx_ready,busy=%b expected 110", {tx5, rdy5, busy5});
    else passed++;
    drive(0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    resetn = 1'b1;
    bad8 = 0;
    bad5 = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (tx8 !== 1'b1) bad8++;
      if (tx5 !== 1'b1) bad5++;
    end
    total++;
    if (bad8 != 0) $display("FAIL idle_dut8: %0d cycles with tx_out low, expected 0", bad8);
    else passed++;
    total++;
    if (bad5 != 0) $display("FAIL idle_dut5: %0d cycles with tx_out low, expected 0", bad5);
    else passed++;
  endtask

  task automatic test_basic_8n1();
    send_frame(0, 9'h0A5, 1'b0, 1'b0, 1'b0, "0101001011", "8n1_a5");
  endtask

  task automatic test_parity();
    send_frame(0, 9'h0A5, 1'b1, 1'b0, 1'b0, "01010010101", "8e1_a5");
    send_frame(0, 9'h0A5, 1'b1, 1'b1, 1'b0, "01010010111", "8o1_a5");
    send_frame(0, 9'h007, 1'b1, 1'b0, 1'b0, "01110000011", "8e1_07");
  endtask

  task automatic test_two_stop();
    send_frame(1, 9'h01F, 1'b1, 1'b1, 1'b1, "011111011", "5o2_1f");
    send_frame(1, 9'h00A, 1'b0, 1'b0, 1'b0, "0010101", "5n1_0a");
  endtask

  task automatic test_back_to_back_stream();
    string      exp[3] = '{"0000000001", "0111111111", "0001111001"};
    logic [7:0] words[3] = '{8'h00, 8'hFF, 8'h3C};
    logic       e;
    int         extra;
    drive(0, 9'(words[0]), 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    for (int f = 0; f < 3; f++) begin
      for (int j = 0; j <= 40; j++) begin
        e = (j < 40) ? (exp[f][j / 4] == "1") : 1'b1;
        total++;
        if (tx8 !== e)
          $display("FAIL stream frame %0d cycle %0d: tx_out=%b expected %b", f, j, tx8, e);
        else passed++;
        total++;
        if (rdy8 !== (j == 40))
          $display("FAIL stream_ready frame %0d cycle %0d: tx_ready=%b expected %b", f, j, rdy8, j == 40);
        else passed++;
        if (j == 5) begin
          data8 = 8'h5A; pen8 = 1'b1; podd8 = 1'b1; ts8 = 1'b1;
        end
        if (j == 20) begin
          if (f < 2) drive(0, 9'(words[f+1]), 1'b1, 1'b0, 1'b0, 1'b0);
          else       drive(0, 9'h05A, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        tick();
      end
    end
    extra = 0;
    for (int i = 0; i < 30; i++) begin
      if (tx8 !== 1'b1 || rdy8 !== 1'b1) extra++;
      tick();
    end
    total++;
    if (extra != 0) $display("FAIL stream_tail: %0d non-idle cycles expected 0", extra);
    else passed++;
  endtask

  task automatic test_reset_mid_frame();
    drive(0, 9'h0A5, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(0, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (17) tick();
    total++;
    if (tx8 !== 1'b0) $display("FAIL mid_data_bit3: tx_out=%b expected 0", tx8);
    else passed++;
    #2;
    resetn = 1'b0;
    #1;
    total++;
    if ({tx8, rdy8, busy8} !== 3'b110)
      $display("FAIL async_reset: tx_out,tx_ready,busy=%b expected 110", {tx8, rdy8, busy8});
    else passed++;
    tick();
    tick();
    resetn = 1'b1;
    tick();
    send_frame(0, 9'h03C, 1'b0, 1'b0, 1'b0, "0001111001", "after_reset");
  endtask

  initial begin
    resetn = 1'b1;
    drive(0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    test_reset();
    test_basic_8n1();
    test_parity();
    test_two_stop();
    test_back_to_back_stream();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised UART transmitter that combines the Tx datapath and its controller into one self-timed block. It accepts a word over a valid/ready handshake and serialises it LSB-first as a start bit, DATA_W data bits, an optional parity bit and one or two stop bits. Each bit lasts CLKS_PER_BIT clock cycles. It sits between the system-side producer (FIFO or register interface) and the serial pin.

## Interface
Parameters:
- DATA_W, 8, data bits per frame; legal range 5..9, elaboration error otherwise
- CLKS_PER_BIT, 16, clock cycles per serial bit; minimum 2, elaboration error otherwise

Ports:
- clk, in, 1, the block's single clock
- resetn, in, 1, asynchronous, active-low reset
- tx_data, in, DATA_W, word to send; sampled only on acceptance
- tx_valid, in, 1, producer has a word
- tx_ready, out, 1, block can accept; high only in IDLE
- parity_en, in, 1, 1 = insert a parity bit; sampled on acceptance
- parity_odd, in, 1, 0 = even parity, 1 = odd parity; sampled on acceptance
- two_stop, in, 1, 1 = two stop bits, 0 = one; sampled on acceptance
- tx_out, out, 1, serial line; idles high
- busy, out, 1, frame in progress (state != IDLE)

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: tx_out=1, tx_ready=1. When tx_valid && tx_ready at a rising edge, the block latches tx_data, parity_en, parity_odd and two_stop, then goes to START.
- START: tx_out=0 for one bit time, then DATA.
- DATA: tx_out = shift_reg[0], starting at bit 0. After each bit time the register shifts right and the bit counter increments. After bit DATA_W-1 the block goes to PARITY if parity_en was latched, otherwise STOP.
- PARITY: tx_out = (^latched_data) ^ parity_odd for one bit time, then STOP.
- STOP: tx_out=1 for one bit time, or two if two_stop was latched, then IDLE.
- Bit timer: counts 0..CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT). It is cleared on acceptance, and a bit ends when it reaches CLKS_PER_BIT-1.
- Bit counter: width $clog2(DATA_W)+1. It counts data bits and, reused in STOP, stop bits. It is cleared on each state change.
- tx_valid is ignored while busy. Input changes mid-frame do not affect the frame in flight.
- Reset (asynchronous, any time including mid-frame): state=IDLE, tx_out=1, tx_ready=1, busy=0, timer and counters 0. The partial frame is abandoned with no truncated stop bit. The first frame after reset release behaves normally.

## Timing
- All outputs are registered, except tx_ready and busy, which are decoded from the state register. There are no combinational paths from inputs to outputs.
- Acceptance edge k: tx_out falls to 0 in cycle k+1 (one-cycle latency).
- Frame length N = 1 + DATA_W + parity_en + (two_stop ? 2 : 1) bits. tx_out holds each bit for exactly CLKS_PER_BIT cycles.
- The state returns to IDLE in cycle k+1+N*CLKS_PER_BIT, and tx_ready rises in that cycle. The earliest next acceptance is at the end of that cycle.
- Back-to-back frames therefore carry exactly one extra idle-high cycle between the last stop bit and the next start bit.
- If tx_valid is held high continuously, frames stream with that spacing. There is no loss or duplication.

## Structure
- Shared package uart_pkg holds:
  - the enum uart_tx_state_t {IDLE, START, DATA, PARITY, STOP}
  - a function that computes the parity bit from a data word and the odd flag
  - the legal ranges of DATA_W and CLKS_PER_BIT as constants, shared with the future Rx block
- One natural sub-module, uart_bit_timer: the CLKS_PER_BIT counter with clear and enable inputs and a bit_done pulse output. It is reused by the Rx side.
- The shift register, bit counter and FSM live in the top-level block.

## Test plan
- Reset value: assert resetn=0 with random inputs -> tx_out=1, tx_ready=1, busy=0. After release with tx_valid=0 for 100 cycles, tx_out stays 1.
- Basic 8N1 (DATA_W=8, CLKS_PER_BIT=4): send 0xA5 with parity_en=0, two_stop=0 -> tx_out reads 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles. tx_ready is low for exactly 40 cycles after acceptance.
- Parity: send 0xA5 with parity_en=1 -> the parity bit is 0 when parity_odd=0 and 1 when parity_odd=1. Send 0x07 even -> parity bit is 1.
- Two stop bits with DATA_W=5, CLKS_PER_BIT=2: send 0x1F with parity_en=1, odd, two_stop=1 -> sequence 0,1,1,1,1,1,0,1,1 (18 cycles). Then one idle cycle before the next start bit.
- Streaming: hold tx_valid high across 3 words (0x00, 0xFF, 0x3C) while changing tx_data mid-frame -> exactly 3 frames with the latched values. Frames start 41 cycles apart (8N1, CLKS_PER_BIT=4).
- Reset mid-frame: assert resetn during DATA bit 3 -> tx_out is 1 in the same cycle, without waiting for a clock edge. A new word accepted after release is sent complete and correct.
